// File: rtl/nn_mat_pkg.sv
// Shared definitions for the 2x2 matrix stream controller: FSM states,
// element count and default parameter values.
`timescale 1ns/1ps
package nn_mat_pkg;

  // Controller phases, in the order a frame walks through them.
  typedef enum logic [2:0] {
    ST_LOAD  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ACK   = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  localparam int N_ELEM      = 4;
  localparam int DEF_WIDTH   = 8;
  localparam int DEF_RES_W   = 64;
  localparam int DEF_TIMEOUT = 64;

endpackage

// File: rtl/mat_stream_ctrl.sv
// Stream sequencer for the 2x2 matrix multiply-chain engine.
// Packs four input elements into the engine operand, runs the engine's
// start/done/done_ack handshake, then replays the four result elements.
// Optional engine watchdog: define MAT_CTRL_TIMEOUT_EN.
//
// Handshakes: a beat transfers on a rising clk edge where valid and ready
// are both high. The controller never withdraws m_valid or changes m_data
// until m_ready accepts the beat; s_ready is a pure decode of the LOAD state.
// Engine side: mm_start is a one-cycle pulse; mm_done is a level held by the
// engine until it sees mm_done_ack, which we keep high until mm_done drops.
`timescale 1ns/1ps
module mat_stream_ctrl
  import nn_mat_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int RES_W          = DEF_RES_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [WIDTH-1:0]          s_data,
  input  logic                      s_valid,
  output logic                      s_ready,
  output logic [WIDTH-1:0]          m_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [N_ELEM*WIDTH-1:0]   mm_A,
  output logic                      mm_start,
  input  logic                      mm_done,
  output logic                      mm_done_ack,
  input  logic [RES_W-1:0]          mm_Res,
  output logic                      busy,
  output logic                      err,
  output logic [15:0]               frame_cnt,
  output logic [2:0]                state_dbg
);

  localparam int DW = N_ELEM * WIDTH;
  localparam logic [1:0] LAST_IDX = 2'(N_ELEM - 1);

  state_e          state_q, state_d;
  logic [DW-1:0]   a_q, a_d;
  logic [DW-1:0]   res_q, res_d;
  logic [1:0]      idx_q, idx_d;
  logic [15:0]     fcnt_q, fcnt_d;

`ifdef MAT_CTRL_TIMEOUT_EN
  logic [15:0]     to_cnt_q, to_cnt_d;
  logic            err_q, err_d;
  // Set when a timed-out frame is abandoned: START then skips the engine.
  logic            flush_q, flush_d;
`else
  // Result bits above the element field and the watchdog limit are not used.
  logic            unused_bits;
  assign unused_bits = ^{mm_Res[RES_W-1:DW], TIMEOUT_CYCLES[0]};
`endif

`ifdef MAT_CTRL_TIMEOUT_EN
  logic            unused_res;
  assign unused_res = ^mm_Res[RES_W-1:DW];
`endif

  // State and datapath registers; reset abandons any frame in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_LOAD;
      a_q      <= '0;
      res_q    <= '0;
      idx_q    <= '0;
      fcnt_q   <= '0;
`ifdef MAT_CTRL_TIMEOUT_EN
      to_cnt_q <= '0;
      err_q    <= 1'b0;
      flush_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      res_q    <= res_d;
      idx_q    <= idx_d;
      fcnt_q   <= fcnt_d;
`ifdef MAT_CTRL_TIMEOUT_EN
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
      flush_q  <= flush_d;
`endif
    end
  end

  // Next-state, pack/unpack shifting and handshake outputs.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    res_d       = res_q;
    idx_d       = idx_q;
    fcnt_d      = fcnt_q;
    s_ready     = 1'b0;
    m_valid     = 1'b0;
    mm_start    = 1'b0;
    mm_done_ack = 1'b0;
`ifdef MAT_CTRL_TIMEOUT_EN
    to_cnt_d    = '0;
    err_d       = err_q;
    flush_d     = flush_q;
`endif
    case (state_q)
      ST_LOAD: begin
        s_ready = 1'b1;
        if (s_valid) begin
          // Row-major arrival: the first element ends up in the MSBs.
          a_d = {a_q[DW-WIDTH-1:0], s_data};
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = ST_START;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      ST_START: begin
        // A stale done (engine left in DONE) is acknowledged away first.
        if (mm_done) begin
          mm_done_ack = 1'b1;
        end else begin
`ifdef MAT_CTRL_TIMEOUT_EN
          if (flush_q) begin
            flush_d = 1'b0;
            state_d = ST_LOAD;
          end else begin
            mm_start = 1'b1;
            state_d  = ST_WAIT;
          end
`else
          mm_start = 1'b1;
          state_d  = ST_WAIT;
`endif
        end
      end
      ST_WAIT: begin
        if (mm_done) begin
          res_d   = mm_Res[DW-1:0];
          state_d = ST_ACK;
        end
`ifdef MAT_CTRL_TIMEOUT_EN
        else if (to_cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          flush_d = 1'b1;
          state_d = ST_START;
        end else begin
          to_cnt_d = to_cnt_q + 16'd1;
        end
`endif
      end
      ST_ACK: begin
        mm_done_ack = 1'b1;
        if (!mm_done) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        m_valid = 1'b1;
        if (m_ready) begin
          res_d = res_q << WIDTH;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            fcnt_d  = fcnt_q + 16'd1;
            state_d = ST_LOAD;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  assign m_data    = res_q[DW-1 -: WIDTH];
  assign mm_A      = a_q;
  assign busy      = (state_q != ST_LOAD);
  assign frame_cnt = fcnt_q;
  assign state_dbg = state_q;
`ifdef MAT_CTRL_TIMEOUT_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_mat_stream_ctrl.sv
// Directed bench for mat_stream_ctrl with a behavioural engine model
// (B = I, C = 1, 4 layers: each element comes back as element + 4, mod 256).
`timescale 1ns/1ps
module tb_mat_stream_ctrl;
  import nn_mat_pkg::*;

  localparam int W       = 8;
  localparam int RW      = 64;
  localparam int ENG_LAT = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [W-1:0]   s_data = '0;
  logic           s_valid = 1'b0;
  logic           s_ready;
  logic [W-1:0]   m_data;
  logic           m_valid;
  logic           m_ready = 1'b0;
  logic [4*W-1:0] mm_A;
  logic           mm_start;
  logic           mm_done = 1'b0;
  logic           mm_done_ack;
  logic [RW-1:0]  mm_Res = '0;
  logic           busy;
  logic           err;
  logic [15:0]    frame_cnt;
  logic [2:0]     state_dbg;

  int checks = 0;
  int errors = 0;

  mat_stream_ctrl #(.WIDTH(W), .RES_W(RW), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .reset(reset),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .mm_A(mm_A), .mm_start(mm_start), .mm_done(mm_done),
    .mm_done_ack(mm_done_ack), .mm_Res(mm_Res),
    .busy(busy), .err(err), .frame_cnt(frame_cnt), .state_dbg(state_dbg)
  );

  // ---------------- engine model ----------------
  bit             eng_force = 1'b0;  // hold done high (engine stuck in DONE)
  bit             eng_dead  = 1'b0;  // never raise done
  bit             eng_busy  = 1'b0;
  int             eng_cnt   = 0;
  logic [4*W-1:0] eng_a     = '0;

  function automatic logic [RW-1:0] eng_calc(input logic [4*W-1:0] a);
    logic [4*W-1:0] r;
    for (int i = 0; i < 4; i++) r[i*W +: W] = a[i*W +: W] + 8'd4;
    return {32'hDEAD_BEEF, r};
  endfunction

  always @(posedge clk) begin
    if (eng_force) begin
      mm_done  <= 1'b1;
      mm_Res   <= '0;
      eng_busy <= 1'b0;
    end else if (reset) begin
      eng_busy <= 1'b0;
    end else if (mm_done) begin
      if (mm_done_ack) mm_done <= 1'b0;
    end else if (eng_busy) begin
      if (eng_cnt <= 1) begin
        eng_busy <= 1'b0;
        if (!eng_dead) begin
          mm_done <= 1'b1;
          mm_Res  <= eng_calc(eng_a);
        end
      end else begin
        eng_cnt <= eng_cnt - 1;
      end
    end else if (mm_start) begin
      eng_a    <= mm_A;
      eng_busy <= 1'b1;
      eng_cnt  <= ENG_LAT;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3,
                            input int max_gap);
    logic [7:0] el [4];
    int n;
    el = '{e0, e1, e2, e3};
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(0, max_gap)) tick();
      s_data  = el[k];
      s_valid = 1'b1;
      n = 0;
      while (!s_ready && n < 300) begin
        tick();
        n++;
      end
      if (n >= 300) begin
        checks++;
        errors++;
        $display("FAIL send_timeout beat%0d: s_ready got 0 expected 1", k);
      end
      tick();
      s_valid = 1'b0;
    end
  endtask

  task automatic recv_frame(input string name,
                            input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3,
                            input int stall_beat, input int max_gap);
    logic [7:0] el [4];
    int n;
    el = '{e0, e1, e2, e3};
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!m_valid && n < 300) begin
        tick();
        n++;
      end
      checks++;
      if (m_valid !== 1'b1) begin
        errors++;
        $display("FAIL %s_valid beat%0d: got %b expected 1", name, k, m_valid);
      end
      checks++;
      if (m_data !== el[k]) begin
        errors++;
        $display("FAIL %s_data beat%0d: got %02h expected %02h", name, k, m_data, el[k]);
      end
      if (k == stall_beat) begin
        m_ready = 1'b0;
        repeat (3) begin
          tick();
          checks++;
          if (m_valid !== 1'b1 || m_data !== el[k]) begin
            errors++;
            $display("FAIL %s_stall_hold beat%0d: got v=%b d=%02h expected v=1 d=%02h",
                     name, k, m_valid, m_data, el[k]);
          end
        end
      end else begin
        repeat ($urandom_range(0, max_gap)) tick();
      end
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    checks++;
    if (s_ready !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0 || mm_start !== 1'b0 ||
        mm_done_ack !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got rdy=%b busy=%b mv=%b st=%b ack=%b err=%b expected 1 0 0 0 0 0",
               s_ready, busy, m_valid, mm_start, mm_done_ack, err);
    end
    checks++;
    if (mm_A !== 32'h0 || m_data !== 8'h00 || frame_cnt !== 16'h0 || state_dbg !== 3'd0) begin
      errors++;
      $display("FAIL reset_data: got A=%h md=%h fc=%0d st=%0d expected 0 0 0 0",
               mm_A, m_data, frame_cnt, state_dbg);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (s_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got rdy=%b busy=%b expected 1 0", s_ready, busy);
    end
  endtask

  task automatic test_basic();
    send_frame(8'd1, 8'd2, 8'd3, 8'd4, 0);
    // One cycle after the last accepted beat the start pulse is out.
    checks++;
    if (mm_start !== 1'b1 || state_dbg !== 3'd1 || mm_A !== 32'h0102_0304) begin
      errors++;
      $display("FAIL basic_start: got st=%b state=%0d A=%h expected 1 1 01020304",
               mm_start, state_dbg, mm_A);
    end
    tick();
    checks++;
    if (mm_start !== 1'b0 || state_dbg !== 3'd2) begin
      errors++;
      $display("FAIL basic_start_pulse: got st=%b state=%0d expected 0 2", mm_start, state_dbg);
    end
    recv_frame("basic", 8'd5, 8'd6, 8'd7, 8'd8, -1, 0);
    checks++;
    if (frame_cnt !== 16'd1 || busy !== 1'b0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_end: got fc=%0d busy=%b rdy=%b expected 1 0 1", frame_cnt, busy, s_ready);
    end
  endtask

  task automatic test_stalls();
    send_frame(8'h10, 8'h20, 8'h30, 8'h40, 3);
    recv_frame("stall", 8'h14, 8'h24, 8'h34, 8'h44, 1, 2);
    checks++;
    if (frame_cnt !== 16'd2) begin
      errors++;
      $display("FAIL stall_frame_cnt: got %0d expected 2", frame_cnt);
    end
  endtask

  task automatic test_full_wrap();
    send_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1);
    tick();
    checks++;
    if (state_dbg !== 3'd2 || mm_A !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL wrap_operand: got state=%0d A=%h expected 2 ffffffff", state_dbg, mm_A);
    end
    recv_frame("wrap", 8'h03, 8'h03, 8'h03, 8'h03, -1, 1);
    checks++;
    if (frame_cnt !== 16'd3) begin
      errors++;
      $display("FAIL wrap_frame_cnt: got %0d expected 3", frame_cnt);
    end
  endtask

  task automatic test_reset_mid();
    send_frame(8'hA0, 8'hA1, 8'hA2, 8'hA3, 0);
    tick();
    checks++;
    if (state_dbg !== 3'd2) begin
      errors++;
      $display("FAIL mid_in_wait: got state=%0d expected 2", state_dbg);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (state_dbg !== 3'd0 || busy !== 1'b0 || s_ready !== 1'b1 || frame_cnt !== 16'd0 ||
        mm_A !== 32'h0) begin
      errors++;
      $display("FAIL mid_async_reset: got state=%0d busy=%b rdy=%b fc=%0d A=%h expected 0 0 1 0 0",
               state_dbg, busy, s_ready, frame_cnt, mm_A);
    end
    repeat (3) tick();
    reset = 1'b0;
    repeat (8) begin
      tick();
      checks++;
      if (m_valid !== 1'b0 || mm_start !== 1'b0) begin
        errors++;
        $display("FAIL mid_idle: got mv=%b st=%b expected 0 0", m_valid, mm_start);
      end
    end
    send_frame(8'h7C, 8'h7D, 8'h7E, 8'h7F, 1);
    recv_frame("mid", 8'h80, 8'h81, 8'h82, 8'h83, -1, 0);
    checks++;
    if (frame_cnt !== 16'd1) begin
      errors++;
      $display("FAIL mid_frame_cnt: got %0d expected 1", frame_cnt);
    end
  endtask

  task automatic test_done_at_reset();
    eng_force = 1'b1;
    reset = 1'b1;
    repeat (3) tick();
    eng_force = 1'b0;
    reset = 1'b0;
    tick();
    checks++;
    if (mm_done !== 1'b1 || mm_done_ack !== 1'b0 || m_valid !== 1'b0 || state_dbg !== 3'd0) begin
      errors++;
      $display("FAIL stale_idle: got done=%b ack=%b mv=%b state=%0d expected 1 0 0 0",
               mm_done, mm_done_ack, m_valid, state_dbg);
    end
    send_frame(8'd9, 8'd10, 8'd11, 8'd12, 0);
    checks++;
    if (mm_done_ack !== 1'b1 || mm_start !== 1'b0 || state_dbg !== 3'd1) begin
      errors++;
      $display("FAIL stale_ack: got ack=%b st=%b state=%0d expected 1 0 1",
               mm_done_ack, mm_start, state_dbg);
    end
    tick();
    checks++;
    if (mm_done_ack !== 1'b0 || mm_start !== 1'b1 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL stale_then_start: got ack=%b st=%b mv=%b expected 0 1 0",
               mm_done_ack, mm_start, m_valid);
    end
    recv_frame("stale", 8'd13, 8'd14, 8'd15, 8'd16, -1, 0);
    checks++;
    if (frame_cnt !== 16'd1) begin
      errors++;
      $display("FAIL stale_frame_cnt: got %0d expected 1", frame_cnt);
    end
  endtask

`ifdef MAT_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    logic [15:0] fc0;
    fc0 = frame_cnt;
    eng_dead = 1'b1;
    send_frame(8'h21, 8'h22, 8'h23, 8'h24, 0);
    tick();
    repeat (63) begin
      checks++;
      if (err !== 1'b0 || state_dbg !== 3'd2 || m_valid !== 1'b0) begin
        errors++;
        $display("FAIL to_waiting: got err=%b state=%0d mv=%b expected 0 2 0", err, state_dbg, m_valid);
      end
      tick();
    end
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL to_early: got err=%b expected 0", err);
    end
    tick();
    checks++;
    if (err !== 1'b1 || state_dbg !== 3'd1 || mm_start !== 1'b0) begin
      errors++;
      $display("FAIL to_fire: got err=%b state=%0d st=%b expected 1 1 0", err, state_dbg, mm_start);
    end
    tick();
    checks++;
    if (state_dbg !== 3'd0 || m_valid !== 1'b0 || frame_cnt !== fc0) begin
      errors++;
      $display("FAIL to_flush: got state=%0d mv=%b fc=%0d expected 0 0 %0d",
               state_dbg, m_valid, frame_cnt, fc0);
    end
    eng_dead = 1'b0;
    send_frame(8'd1, 8'd2, 8'd3, 8'd4, 0);
    recv_frame("to_next", 8'd5, 8'd6, 8'd7, 8'd8, -1, 0);
    checks++;
    if (err !== 1'b1 || frame_cnt !== fc0 + 16'd1) begin
      errors++;
      $display("FAIL to_after: got err=%b fc=%0d expected 1 %0d", err, frame_cnt, fc0 + 16'd1);
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_stalls();
    test_full_wrap();
    test_reset_mid();
    test_done_at_reset();
`ifdef MAT_CTRL_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

endmodule
